maxpool_scheduler: RTL
======================

# maxpool_scheduler

- Reads the feature map that the convolution scheduler writes into feature memory.
- Applies 2x2, stride-2 max pooling and writes the pooled map to the pool output memory.
- Mode 0: pools the 24x24 layer-0 conv output down to 12x12 (the layer-1 conv input).
- Mode 1: pools the 8x8 layer-1 conv output down to 4x4.
- Sits between the conv stage and the next layer or classifier, and is started by the same top-level controller.

## Interface
- ADDR_BIT, 10, width of both memory address buses
- DATA_BIT, 16, signed feature/pool data width
- RD_BASE, 0, base address of the input feature map in feature memory
- WR_BASE, 0, base address of the pooled map in pool output memory

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  start request; accepted only in IDLE
- mode  in  1  0: 24x24 in / 12x12 out; 1: 8x8 in / 4x4 out
- rd_en  out  1  feature memory read enable
- rd_addr  out  ADDR_BIT  feature memory read address
- rd_data  in  DATA_BIT  feature memory data, valid 1 cycle after rd_en
- wr_en  out  1  pool memory write enable
- wr_addr  out  ADDR_BIT  pool memory write address
- wr_data  out  DATA_BIT  pooled value
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on the final write

## Operation
- States: IDLE, READ, DRAIN, WRITE.
- IDLE→READ when start=1. On acceptance: mode is latched into mode_r, and window counters px, py and read index k are cleared. start is ignored outside IDLE.
- READ lasts 4 cycles, k=0..3. It drives rd_en=1 and rd_addr = RD_BASE + (2*py+dy)*in_dim + 2*px+dx, with (dy,dx) = (0,0),(0,1),(1,0),(1,1) for k=0..3.
  - in_dim = 24 for mode_r=0, 8 for mode_r=1; out_dim = in_dim/2.
- DRAIN lasts 1 cycle and captures the 4th datum.
- WRITE lasts 1 cycle. It drives wr_en=1, wr_addr = WR_BASE + py*out_dim + px, wr_data = max_r.
  - After WRITE, px increments. When px wraps from out_dim-1 to 0, py increments.
  - On the last window (px = py = out_dim-1): done=1 and next state is IDLE. Otherwise next state is READ.
- Max register:
  - On the cycle after k=0, max_r loads rd_data unconditionally.
  - On the cycles after k=1..3, max_r replaces its value only if rd_data > max_r (signed compare).
- All address arithmetic is ADDR_BIT-wide and wraps modulo 2^ADDR_BIT.
- Outputs are combinational from state. When inactive: rd_addr=0, wr_addr=0, wr_data=0, rd_en=0, wr_en=0.

## Timing
- Reset values: rd_en=0, rd_addr=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0; state=IDLE; all counters and max_r are 0.
- Feature memory has fixed 1-cycle synchronous read latency, with no backpressure.
- 6 cycles per window.
- Run length from the first READ cycle to done:
  - mode 0: 144*6 = 864 cycles.
  - mode 1: 16*6 = 96 cycles.
- busy rises the cycle after start is sampled and falls the cycle after done.
- start=1 in the done cycle is ignored. A start held high in the following IDLE cycle begins a new run.
- Asserting rst_n low mid-run returns the block to IDLE immediately. It forces all outputs to their reset values and drops the partial window. The next start begins at window (0,0).
- A change of mode during a run has no effect, because mode_r is used.

## Configuration
- MAXPOOL_RELU_EN:
  - Defined: wr_data = (max_r < 0) ? 0 : max_r, which fuses ReLU into pooling.
  - Undefined: wr_data = max_r unmodified.
- Timing is identical either way.

## Structure
- Shared package cnn_sched_pkg holds:
  - state encodings (IDLE=0, READ=1, DRAIN=2, WRITE=3)
  - dimension constants: POOL_IN_DIM_L0=24, POOL_IN_DIM_L1=8, POOL_OUT_DIM_L0=12, POOL_OUT_DIM_L1=4
- One sub-module, maxpool_window_max, holds:
  - max_r
  - the first/subsequent load control
  - the signed compare
  - the optional ReLU clamp
- Sequencing and address generation stay in the top module.

## Test plan
- **Mode 0 ramp.** Stimulus: feature mem[i]=i. Response:
  - window (0,0) reads addresses 0,1,24,25.
  - pool[0]=25, pool[1]=27, pool[12]=73, pool[143]=575.
  - done exactly 864 cycles after the first READ.
- **Mode 1 negative ramp.** Stimulus: mem[i]=-i. Response:
  - without macro: pool[0]=0, pool[1]=-2, pool[15]=-54.
  - with MAXPOOL_RELU_EN: all 16 outputs are 0.
- **Max position sweep.** Stimulus: in mode 1, place a single 100 at k=0, 1, 2, 3 of window (0,0) with other values -7; also an all-equal window of 9. Response: pool[0]=100 in each case; pool[0]=9 for the all-equal window.
- **Start handling.** Stimulus: pulse start during a run at window 5. Response: no restart and no second done. Then hold start high through done: a second run starts one cycle after the IDLE cycle.
- **Reset mid-run.** Stimulus: assert rst_n low at window 50, WRITE cycle. Response: all outputs are 0 while reset is asserted. After release and start, the first rd_addr=0 and wr_addr of the first write is WR_BASE.
- **Mode latch and base offsets.** Stimulus: RD_BASE=576, WR_BASE=100, mode toggled mid-run. Response: first rd_addr=576, first wr_addr=100, and the run completes with mode-0 geometry.

Source files
------------

// File: rtl/cnn_sched_pkg.sv
// Shared definitions for the CNN scheduler blocks: the sequencing
// state encoding and the feature-map dimensions used by the pooling stage.
package cnn_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        WRITE = 2'd3
    } pool_state_e;

    localparam int POOL_IN_DIM_L0  = 24;
    localparam int POOL_IN_DIM_L1  = 8;
    localparam int POOL_OUT_DIM_L0 = 12;
    localparam int POOL_OUT_DIM_L1 = 4;

    // Wide enough to hold a window coordinate up to POOL_OUT_DIM_L0-1.
    localparam int POOL_CNT_BIT    = 4;

    // Output (pooled) side length for a given pooling mode.
    function automatic int poolOutDim(input logic modeSel);
        return modeSel ? POOL_OUT_DIM_L1 : POOL_OUT_DIM_L0;
    endfunction

endpackage

// File: rtl/maxpool_window_max.sv
// Running maximum over one 2x2 pooling window.
// The first datum of a window loads unconditionally; later data replace the
// held value only when strictly larger (signed).
// Build option MAXPOOL_RELU_EN: when defined, negative maxima are clamped to
// zero on the output, fusing ReLU into pooling.
module maxpool_window_max
    import cnn_sched_pkg::*;
#(
    parameter int DATA_BIT = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                first_i,
    input  logic                update_i,
    input  logic [DATA_BIT-1:0] data_i,
    output logic [DATA_BIT-1:0] pooled_o
);

    logic [DATA_BIT-1:0] max_q;
    logic [DATA_BIT-1:0] max_d;

    // Choose between a fresh load, a signed-greater replacement, or hold.
    always_comb begin
        max_d = max_q;
        if (first_i) begin
            max_d = data_i;
        end else if (update_i && ($signed(data_i) > $signed(max_q))) begin
            max_d = data_i;
        end
    end

    // Holding register for the window maximum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_q <= '0;
        end else begin
            max_q <= max_d;
        end
    end

    // Present the pooled value, optionally clamped at zero.
    always_comb begin
`ifdef MAXPOOL_RELU_EN
        pooled_o = max_q[DATA_BIT-1] ? '0 : max_q;
`else
        pooled_o = max_q;
`endif
    end

endmodule

// File: rtl/maxpool_scheduler.sv
// 2x2 stride-2 max pooling sequencer. Walks the output windows row by row,
// reading four input pixels per window from feature memory (1-cycle read
// latency), then writes the window maximum to pool output memory.
// Mode 0 pools 24x24 -> 12x12, mode 1 pools 8x8 -> 4x4.
// Build option MAXPOOL_RELU_EN: clamps negative pooled values to zero
// (handled inside maxpool_window_max); timing is unchanged.
module maxpool_scheduler
    import cnn_sched_pkg::*;
#(
    parameter int ADDR_BIT = 10,
    parameter int DATA_BIT = 16,
    parameter int RD_BASE  = 0,
    parameter int WR_BASE  = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                mode,
    output logic                rd_en,
    output logic [ADDR_BIT-1:0] rd_addr,
    input  logic [DATA_BIT-1:0] rd_data,
    output logic                wr_en,
    output logic [ADDR_BIT-1:0] wr_addr,
    output logic [DATA_BIT-1:0] wr_data,
    output logic                busy,
    output logic                done
);

    pool_state_e             state_q, state_d;
    logic                    mode_q, mode_d;
    logic [POOL_CNT_BIT-1:0] px_q, px_d;
    logic [POOL_CNT_BIT-1:0] py_q, py_d;
    logic [1:0]              k_q, k_d;

    logic [ADDR_BIT-1:0]     inDim, outDim, pxA, pyA;
    logic [ADDR_BIT-1:0]     rdAddrCalc, wrAddrCalc;
    logic                    lastCol, lastRow;
    logic                    firstLoad, maxUpdate;
    logic [DATA_BIT-1:0]     pooled;

    // Read data for index k arrives one cycle later, so the first load
    // happens at k=1 and the last compare lands in DRAIN.
    assign firstLoad = (state_q == READ) && (k_q == 2'd1);
    assign maxUpdate = ((state_q == READ) && k_q[1]) || (state_q == DRAIN);

    maxpool_window_max #(
        .DATA_BIT (DATA_BIT)
    ) u_window_max (
        .clk      (clk),
        .rst_n    (rst_n),
        .first_i  (firstLoad),
        .update_i (maxUpdate),
        .data_i   (rd_data),
        .pooled_o (pooled)
    );

    // Geometry for the latched mode and address generation; k selects (dy,dx).
    always_comb begin
        inDim      = mode_q ? ADDR_BIT'(POOL_IN_DIM_L1) : ADDR_BIT'(POOL_IN_DIM_L0);
        outDim     = ADDR_BIT'(poolOutDim(mode_q));
        pxA        = ADDR_BIT'(px_q);
        pyA        = ADDR_BIT'(py_q);
        rdAddrCalc = ADDR_BIT'(RD_BASE) + (((pyA << 1) + ADDR_BIT'(k_q[1])) * inDim)
                     + (pxA << 1) + ADDR_BIT'(k_q[0]);
        wrAddrCalc = ADDR_BIT'(WR_BASE) + (pyA * outDim) + pxA;
        lastCol    = (pxA == (outDim - ADDR_BIT'(1)));
        lastRow    = (pyA == (outDim - ADDR_BIT'(1)));
    end

    // Next-state, window stepping and state-decoded outputs.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        px_d    = px_q;
        py_d    = py_q;
        k_d     = k_q;
        rd_en   = 1'b0;
        rd_addr = '0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        busy    = (state_q != IDLE);
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = READ;
                    mode_d  = mode;
                    px_d    = '0;
                    py_d    = '0;
                    k_d     = '0;
                end
            end
            READ: begin
                rd_en   = 1'b1;
                rd_addr = rdAddrCalc;
                k_d     = k_q + 2'd1;
                if (k_q == 2'd3) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                state_d = WRITE;
            end
            WRITE: begin
                wr_en   = 1'b1;
                wr_addr = wrAddrCalc;
                wr_data = pooled;
                state_d = READ;
                if (lastCol) begin
                    px_d = '0;
                    if (lastRow) begin
                        py_d    = '0;
                        done    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        py_d = py_q + POOL_CNT_BIT'(1);
                    end
                end else begin
                    px_d = px_q + POOL_CNT_BIT'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, latched mode and window counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mode_q  <= 1'b0;
            px_q    <= '0;
            py_q    <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            px_q    <= px_d;
            py_q    <= py_d;
            k_q     <= k_d;
        end
    end

endmodule
